// File: rtl/mac_act_collector.sv
// Activation/collection stage after the adder array: ReLU (or leaky ReLU when
// LEAKY_RELU_EN is defined), a show-ahead FIFO, valid/ready output and per-layer neuron accounting.
module mac_act_collector #(
    parameter int D_LEN      = 32,
    parameter int EXP_W      = 8,
    parameter int MAN_W      = 23,
    parameter int DEPTH      = 8,
    parameter int CNT_W      = 10,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     layer_start,
    input  logic [CNT_W-1:0]         neuron_total,
    input  logic                     mac_valid,
    input  logic [D_LEN-1:0]         mac_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [D_LEN-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     busy,
    output logic                     layer_done,
    output logic                     overflow_err,
    output logic [1:0]               state_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   total_q, total_d;
    logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
    logic               ovf_q, ovf_d;
    logic               act_valid_q;
    logic [D_LEN-1:0]   act_data_q;
    logic [D_LEN-1:0]   mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]        level_q;
    logic [AW+1:0]      occupancy;
    logic               room, beat, accept, push, pop;
    logic [D_LEN-1:0]   act_in;

    function automatic logic [D_LEN-1:0] activate(input logic [D_LEN-1:0] x);
`ifdef LEAKY_RELU_EN
        logic [EXP_W-1:0] e;
        e = x[D_LEN-2 -: EXP_W];
        activate = x;
        if (x[D_LEN-1]) begin
            // inf/NaN keep their encoding; small magnitudes underflow to +0
            if (e == '1)
                activate = x;
            else if (e > EXP_W'(LEAK_SHIFT))
                activate = {1'b1, e - EXP_W'(LEAK_SHIFT), x[MAN_W-1:0]};
            else
                activate = '0;
        end
`else
        activate = x[D_LEN-1] ? '0 : x;
`endif
    endfunction

`ifndef LEAKY_RELU_EN
    logic [31:0] unused_cfg;
    assign unused_cfg = 32'(LEAK_SHIFT + MAN_W + EXP_W);
`endif

    assign act_in = activate(mac_in);

    // The activation register's slot is reserved so a registered result always fits.
    assign occupancy = {1'b0, level_q} + {{(AW + 1){1'b0}}, act_valid_q};
    assign room      = occupancy < (AW + 2)'(DEPTH);
    assign accept    = beat && room;
    assign push      = act_valid_q;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_d   = state_q;
        total_d   = total_q;
        acc_cnt_d = acc_cnt_q;
        ovf_d     = ovf_q;
        beat      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (layer_start) begin
                    total_d   = neuron_total;
                    acc_cnt_d = '0;
                    ovf_d     = 1'b0;
                    state_d   = (neuron_total == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (acc_cnt_q == total_q) begin
                    state_d = S_DRAIN;
                end else if (mac_valid) begin
                    // A dropped beat still counts so the layer always terminates.
                    beat      = 1'b1;
                    acc_cnt_d = acc_cnt_q + CNT_W'(1);
                    if (!room) ovf_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (!act_valid_q && level_q == '0) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            total_q     <= '0;
            acc_cnt_q   <= '0;
            ovf_q       <= 1'b0;
            act_valid_q <= 1'b0;
            act_data_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
        end else begin
            state_q     <= state_d;
            total_q     <= total_d;
            acc_cnt_q   <= acc_cnt_d;
            ovf_q       <= ovf_d;
            act_valid_q <= accept;
            if (accept) act_data_q <= act_in;
            if (push)   wr_ptr_q   <= wr_ptr_q + AW'(1);
            if (pop)    rd_ptr_q   <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + (AW + 1)'(1);
                2'b01:   level_q <= level_q - (AW + 1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= act_data_q;
    end

    assign out_valid    = (level_q != '0);
    assign out_data     = out_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_level   = level_q;
    assign busy         = (state_q != S_IDLE);
    assign layer_done   = (state_q == S_DONE);
    assign overflow_err = ovf_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_mac_act_collector.sv
// Self-checking bench for mac_act_collector: scoreboard of activated results,
// layer accounting, backpressure, overflow, reset and activation corner values.
module tb_mac_act_collector;
    localparam int D_LEN = 32;
    localparam int DEPTH = 8;
    localparam int CNT_W = 10;

    logic              clk;
    logic              rst_n;
    logic              layer_start;
    logic [CNT_W-1:0]  neuron_total;
    logic              mac_valid;
    logic [D_LEN-1:0]  mac_in;
    logic              out_valid;
    logic              out_ready;
    logic [D_LEN-1:0]  out_data;
    logic [3:0]        fifo_level;
    logic              busy;
    logic              layer_done;
    logic              overflow_err;
    logic [1:0]        state_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [D_LEN-1:0] exp_q[$];

    mac_act_collector #(.D_LEN(D_LEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .layer_start(layer_start), .neuron_total(neuron_total),
        .mac_valid(mac_valid), .mac_in(mac_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .fifo_level(fifo_level), .busy(busy), .layer_done(layer_done),
        .overflow_err(overflow_err), .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_act(input logic [31:0] x);
`ifdef LEAKY_RELU_EN
        logic [7:0] e;
        e = x[30:23];
        if (!x[31] || e == 8'hFF) return x;
        if (e > 8'd3) return {1'b1, e - 8'd3, x[22:0]};
        return 32'h0;
`else
        return x[31] ? 32'h0 : x;
`endif
    endfunction

    // Scoreboard: every handshake on the output is checked against the queue head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output: got %h, expected nothing", out_data);
            end else begin
                if (out_data !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL out_data: got %h expected %h", out_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_beat(input logic [31:0] v, input bit will_accept);
        mac_valid = 1'b1;
        mac_in    = v;
        if (will_accept) exp_q.push_back(model_act(v));
        tick();
        mac_valid = 1'b0;
    endtask

    task automatic start_layer(input int n);
        neuron_total = CNT_W'(n);
        layer_start  = 1'b1;
        tick();
        layer_start  = 1'b0;
    endtask

    task automatic count_done(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (layer_done === 1'b1) pulses++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (fifo_level !== 4'd0) begin n_err++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (layer_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", layer_done); end
        n_cmp++; if (overflow_err !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", overflow_err); end
        n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h expected 0", out_data); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int pulses;
        out_ready = 1'b1;
        start_layer(3);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b expected 1", busy); end
        drive_beat(32'h3F800000, 1'b1);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_latency1: got %b expected 0", out_valid); end
        drive_beat(32'hC0000000, 1'b1);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_latency2: got %b expected 1", out_valid); end
        drive_beat(32'h40400000, 1'b1);
        count_done(20, pulses);
        n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL basic_done_pulses: got %0d expected 1", pulses); end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL basic_drained: got %0d left expected 0", exp_q.size()); end
        n_cmp++; if (overflow_err !== 1'b0) begin n_err++; $display("FAIL basic_ovf: got %b expected 0", overflow_err); end
    endtask

    task automatic test_backpressure();
        int pulses;
        out_ready = 1'b0;
        start_layer(10);
        for (int i = 0; i < 10; i++) drive_beat($urandom(), i < DEPTH);
        tick();
        n_cmp++; if (fifo_level !== 4'd8) begin n_err++; $display("FAIL full_level: got %0d expected 8", fifo_level); end
        n_cmp++; if (overflow_err !== 1'b1) begin n_err++; $display("FAIL full_ovf: got %b expected 1", overflow_err); end
        n_cmp++; if (layer_done !== 1'b0) begin n_err++; $display("FAIL full_early_done: got %b expected 0", layer_done); end
        out_ready = 1'b1;
        count_done(25, pulses);
        n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL full_done_pulses: got %0d expected 1", pulses); end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL full_drained: got %0d left expected 0", exp_q.size()); end
        n_cmp++; if (overflow_err !== 1'b1) begin n_err++; $display("FAIL full_ovf_sticky: got %b expected 1", overflow_err); end
    endtask

    task automatic test_simultaneous();
        int pulses;
        out_ready = 1'b0;
        start_layer(15);
        for (int i = 0; i < 5; i++) drive_beat($urandom(), 1'b1);
        n_cmp++; if (fifo_level !== 4'd4) begin n_err++; $display("FAIL simul_fill: got %0d expected 4", fifo_level); end
        n_cmp++; if (overflow_err !== 1'b0) begin n_err++; $display("FAIL simul_ovf_cleared: got %b expected 0", overflow_err); end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_beat($urandom(), 1'b1);
            n_cmp++;
            if (fifo_level !== 4'd4) begin n_err++; $display("FAIL simul_level[%0d]: got %0d expected 4", i, fifo_level); end
        end
        count_done(20, pulses);
        n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL simul_done_pulses: got %0d expected 1", pulses); end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL simul_drained: got %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_zero_and_ignored();
        int pulses;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) drive_beat(32'h3F800000, 1'b0);
        tick();
        n_cmp++; if (fifo_level !== 4'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL idle_mac_ignored: got level %0d valid %b expected 0 0", fifo_level, out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b expected 0", busy); end
        start_layer(0);
        n_cmp++; if (layer_done !== 1'b1) begin n_err++; $display("FAIL zero_done: got %b expected 1", layer_done); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL zero_out_valid: got %b expected 0", out_valid); end
        tick();
        n_cmp++; if (layer_done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL zero_after: got done %b busy %b expected 0 0", layer_done, busy); end
        start_layer(2);
        neuron_total = CNT_W'(5);
        layer_start  = 1'b1;
        drive_beat(32'h40A00000, 1'b1);
        layer_start  = 1'b0;
        drive_beat(32'hBF800000, 1'b1);
        count_done(15, pulses);
        n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL run_start_ignored_done: got %0d expected 1", pulses); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL run_start_ignored_busy: got %b expected 0", busy); end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL run_start_ignored_drained: got %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_activation();
        int pulses;
        logic [31:0] vec [8];
        vec = '{32'hC1000000, 32'h80800000, 32'hFF800000, 32'h80000000,
                32'hFFC00000, 32'h7F800000, 32'h00000000, 32'hC2280000};
        out_ready = 1'b1;
        start_layer(8);
        for (int i = 0; i < 8; i++) drive_beat(vec[i], 1'b1);
        count_done(20, pulses);
        n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL act_done_pulses: got %0d expected 1", pulses); end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL act_drained: got %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_layer();
        int pulses;
        out_ready = 1'b0;
        start_layer(10);
        for (int i = 0; i < 5; i++) drive_beat($urandom(), 1'b1);
        tick();
        n_cmp++; if (fifo_level !== 4'd5) begin n_err++; $display("FAIL midrst_fill: got %0d expected 5", fifo_level); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (fifo_level !== 4'd0) begin n_err++; $display("FAIL midrst_level: got %0d expected 0", fifo_level); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        count_done(10, pulses);
        n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL midrst_no_done: got %0d expected 0", pulses); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_stay_empty: got %b expected 0", out_valid); end
    endtask

    initial begin
        rst_n        = 1'b0;
        layer_start  = 1'b0;
        neuron_total = '0;
        mac_valid    = 1'b0;
        mac_in       = '0;
        out_ready    = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_simultaneous();
        test_zero_and_ignored();
        test_activation();
        test_reset_mid_layer();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
